// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared opcodes, phase code and timeout limit for the memory stage
package mem_stage_pkg;

    localparam logic       EXEC          = 1'b1;
    localparam logic [4:0] OP_LOAD       = 5'b10000;
    localparam logic [4:0] OP_STORE      = 5'b10001;
    localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

    function automatic logic [4:0] opcode_of(input logic [15:0] ir);
        return ir[15:11];
    endfunction

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: issues data-memory requests, waits for ack or timeout
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic        dw,
    input  logic [15:0] smdr1,
    output logic        d_req,
    output logic        d_we,
    output logic [15:0] d_addr,
    output logic [15:0] d_wdata,
    input  logic        d_ack,
    input  logic [15:0] d_rdata,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        stall,
    output logic        merr
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    logic        r_fsm, w_fsm_next;
    logic [3:0]  r_wait_cnt, w_wait_cnt;
    logic [15:0] r_ir, w_ir;
    logic        r_d_req, w_d_req;
    logic        r_d_we, w_d_we;
    logic [15:0] r_d_addr, w_d_addr;
    logic [15:0] r_d_wdata, w_d_wdata;
    logic [15:0] r_wb_ir, w_wb_ir;
    logic [15:0] r_reg_c1, w_reg_c1;
    logic        r_stall, w_stall;
    logic        r_merr, w_merr;

    logic        w_go;
    logic        w_is_mem;
    logic [3:0]  w_wait_inc;
    logic        w_timeout;

    assign w_go       = (state == EXEC);
    assign w_is_mem   = (opcode_of(mem_ir) == OP_LOAD) || dw;
    assign w_wait_inc = r_wait_cnt + 4'd1;
    assign w_timeout  = (w_wait_inc == TIMEOUT_LIMIT);

    always_ff @(posedge clock) begin
        if (!reset) r_fsm <= ST_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        if (r_fsm == ST_IDLE) begin
            if (w_go && w_is_mem) w_fsm_next = ST_ACCESS;
        end else begin
            if (d_ack || w_timeout) w_fsm_next = ST_IDLE;
        end
    end

    // Next values of the registered outputs; ACCESS ignores the pipeline phase entirely.
    always_comb begin
        w_wait_cnt = r_wait_cnt;
        w_ir       = r_ir;
        w_d_req    = r_d_req;
        w_d_we     = r_d_we;
        w_d_addr   = r_d_addr;
        w_d_wdata  = r_d_wdata;
        w_wb_ir    = r_wb_ir;
        w_reg_c1   = r_reg_c1;
        w_stall    = r_stall;
        w_merr     = r_merr;
        if (r_fsm == ST_IDLE) begin
            if (w_go && w_is_mem) begin
                w_d_req    = 1'b1;
                w_d_we     = dw;
                w_d_addr   = reg_C;
                w_d_wdata  = smdr1;
                w_ir       = mem_ir;
                w_wb_ir    = 16'h0000;
                w_stall    = 1'b1;
                w_wait_cnt = 4'd0;
            end else if (w_go) begin
                w_wb_ir  = mem_ir;
                w_reg_c1 = reg_C;
                w_stall  = 1'b0;
            end
        end else if (d_ack) begin
            w_d_req  = 1'b0;
            w_d_we   = 1'b0;
            w_stall  = 1'b0;
            w_wb_ir  = r_ir;
            w_reg_c1 = (opcode_of(r_ir) == OP_LOAD) ? d_rdata : r_d_addr;
        end else begin
            w_wait_cnt = w_wait_inc;
            if (w_timeout) begin
                w_d_req = 1'b0;
                w_d_we  = 1'b0;
                w_merr  = 1'b1;
                w_wb_ir = 16'h0000;
                w_stall = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
            r_ir       <= 16'h0000;
            r_d_req    <= 1'b0;
            r_d_we     <= 1'b0;
            r_d_addr   <= 16'h0000;
            r_d_wdata  <= 16'h0000;
            r_wb_ir    <= 16'h0000;
            r_reg_c1   <= 16'h0000;
            r_stall    <= 1'b0;
            r_merr     <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt;
            r_ir       <= w_ir;
            r_d_req    <= w_d_req;
            r_d_we     <= w_d_we;
            r_d_addr   <= w_d_addr;
            r_d_wdata  <= w_d_wdata;
            r_wb_ir    <= w_wb_ir;
            r_reg_c1   <= w_reg_c1;
            r_stall    <= w_stall;
            r_merr     <= w_merr;
        end
    end

    assign d_req   = r_d_req;
    assign d_we    = r_d_we;
    assign d_addr  = r_d_addr;
    assign d_wdata = r_d_wdata;
    assign wb_ir   = r_wb_ir;
    assign reg_C1  = r_reg_c1;
    assign stall   = r_stall;
    assign merr    = r_merr;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [15:0] IR_ADD   = 16'h0812;
    localparam logic [15:0] IR_LOAD  = 16'h8005;
    localparam logic [15:0] IR_STORE = 16'h8800;

    logic        clock = 1'b0;
    logic        reset, state, dw, d_ack;
    logic [15:0] mem_ir, reg_C, smdr1, d_rdata;
    logic        d_req, d_we, stall, merr;
    logic [15:0] d_addr, d_wdata, wb_ir, reg_C1;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    mem_stage dut (
        .clock(clock), .reset(reset), .state(state), .mem_ir(mem_ir),
        .reg_C(reg_C), .dw(dw), .smdr1(smdr1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .wb_ir(wb_ir), .reg_C1(reg_C1), .stall(stall), .merr(merr)
    );

    always #5 clock = ~clock;

    // Reference model: one outstanding operation tracked by its age in edges.
    bit          m_busy;
    int          m_age;
    logic [15:0] m_op_ir, m_op_addr;
    logic        m_req, m_we, m_stall, m_merr;
    logic [15:0] m_addr, m_wdata, m_wb, m_c1;

    always @(posedge clock) begin
        if (!reset) begin
            m_busy = 0; m_age = 0; m_op_ir = 0; m_op_addr = 0;
            m_req = 0; m_we = 0; m_stall = 0; m_merr = 0;
            m_addr = 0; m_wdata = 0; m_wb = 0; m_c1 = 0;
        end else if (m_busy) begin
            m_age = m_age + 1;
            if (d_ack) begin
                m_busy = 0; m_req = 0; m_we = 0; m_stall = 0; m_wb = m_op_ir;
                m_c1 = (m_op_ir[15:11] == OP_LOAD) ? d_rdata : m_op_addr;
            end else if (m_age >= 15) begin
                m_busy = 0; m_req = 0; m_we = 0; m_merr = 1; m_wb = 0; m_stall = 0;
            end
        end else if (state == EXEC) begin
            if (mem_ir[15:11] == OP_LOAD || dw) begin
                m_busy = 1; m_age = 0; m_op_ir = mem_ir; m_op_addr = reg_C;
                m_req = 1; m_we = dw; m_addr = reg_C; m_wdata = smdr1;
                m_wb = 0; m_stall = 1;
            end else begin
                m_wb = mem_ir; m_c1 = reg_C; m_stall = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("model d_req",   {15'd0, d_req}, {15'd0, m_req});
            chk("model d_we",    {15'd0, d_we},  {15'd0, m_we});
            chk("model d_addr",  d_addr,  m_addr);
            chk("model d_wdata", d_wdata, m_wdata);
            chk("model wb_ir",   wb_ir,   m_wb);
            chk("model reg_C1",  reg_C1,  m_c1);
            chk("model stall",   {15'd0, stall}, {15'd0, m_stall});
            chk("model merr",    {15'd0, merr},  {15'd0, m_merr});
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 0; state = 0; dw = 0; d_ack = 0;
        mem_ir = 0; reg_C = 0; smdr1 = 0; d_rdata = 0;
        tick(); started = 1'b1; tick();
        chk("rst wb_ir", wb_ir, 16'h0000);
        chk("rst reg_C1", reg_C1, 16'h0000);
        chk("rst d_req", {15'd0, d_req}, 16'h0000);
        chk("rst stall", {15'd0, stall}, 16'h0000);
        chk("rst merr", {15'd0, merr}, 16'h0000);
        reset = 1;

        // ADD pass-through, then hold while not exec
        mem_ir = IR_ADD; reg_C = 16'h1234; state = EXEC;
        tick();
        chk("add wb_ir", wb_ir, 16'h0812);
        chk("add reg_C1", reg_C1, 16'h1234);
        chk("add stall", {15'd0, stall}, 16'h0000);
        chk("add d_req", {15'd0, d_req}, 16'h0000);
        state = 0; mem_ir = 16'h0FFF; reg_C = 16'h9999;
        tick();
        chk("hold wb_ir", wb_ir, 16'h0812);

        // LOAD acked on the third edge after the request
        mem_ir = IR_LOAD; reg_C = 16'h0040; d_rdata = 16'hBEEF; state = EXEC;
        tick();
        chk("ld d_req", {15'd0, d_req}, 16'h0001);
        chk("ld d_addr", d_addr, 16'h0040);
        chk("ld wb_ir bubble", wb_ir, 16'h0000);
        state = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ld stall", {15'd0, stall}, 16'h0001);
        end
        d_ack = 1;
        tick();
        chk("ld reg_C1", reg_C1, 16'hBEEF);
        chk("ld wb_ir", wb_ir, IR_LOAD);
        chk("ld stall done", {15'd0, stall}, 16'h0000);
        tick();
        chk("idle ack ignored", {15'd0, d_req}, 16'h0000);
        d_ack = 0;

        // STORE acked on the next edge
        mem_ir = IR_STORE; dw = 1; smdr1 = 16'h5A5A; reg_C = 16'h0010; state = EXEC;
        tick();
        chk("st d_we", {15'd0, d_we}, 16'h0001);
        chk("st d_wdata", d_wdata, 16'h5A5A);
        chk("st d_addr", d_addr, 16'h0010);
        state = 0; dw = 0; d_ack = 1;
        tick();
        chk("st d_we done", {15'd0, d_we}, 16'h0000);
        chk("st wb_ir", wb_ir, IR_STORE);
        chk("st reg_C1", reg_C1, 16'h0010);
        d_ack = 0;

        // back-to-back STORE then LOAD
        mem_ir = IR_STORE; dw = 1; smdr1 = 16'h1111; reg_C = 16'h0020; state = EXEC;
        tick();
        state = 0; d_ack = 1;
        tick();
        chk("b2b gap", {15'd0, d_req}, 16'h0000);
        chk("b2b st wb", wb_ir, IR_STORE);
        d_ack = 0; mem_ir = IR_LOAD; dw = 0; reg_C = 16'h0030; d_rdata = 16'h2222; state = EXEC;
        tick();
        chk("b2b ld req", {15'd0, d_req}, 16'h0001);
        chk("b2b ld addr", d_addr, 16'h0030);
        state = 0; d_ack = 1;
        tick();
        chk("b2b ld wb", wb_ir, IR_LOAD);
        chk("b2b ld data", reg_C1, 16'h2222);

        // ack already high on the request edge must not complete it
        d_rdata = 16'h3333; reg_C = 16'h0035; state = EXEC;
        tick();
        chk("early ack req", {15'd0, d_req}, 16'h0001);
        state = 0;
        tick();
        chk("early ack data", reg_C1, 16'h3333);
        d_ack = 0;

        // timeout after 15 wait edges
        mem_ir = IR_LOAD; reg_C = 16'h0050; state = EXEC;
        tick();
        state = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to waiting", {15'd0, d_req}, 16'h0001);
        end
        tick();
        chk("to merr", {15'd0, merr}, 16'h0001);
        chk("to wb_ir", wb_ir, 16'h0000);
        chk("to stall", {15'd0, stall}, 16'h0000);
        chk("to d_req", {15'd0, d_req}, 16'h0000);
        mem_ir = IR_ADD; reg_C = 16'h0777; state = EXEC;
        tick();
        chk("merr sticky", {15'd0, merr}, 16'h0001);

        // reset two cycles into a LOAD, then a late ack
        mem_ir = IR_LOAD; reg_C = 16'h0060; d_rdata = 16'hDEAD; state = EXEC;
        tick();
        state = 0;
        tick(); tick();
        reset = 0;
        tick();
        chk("rst mid d_req", {15'd0, d_req}, 16'h0000);
        chk("rst mid merr", {15'd0, merr}, 16'h0000);
        reset = 1; d_ack = 1;
        tick();
        chk("late ack wb_ir", wb_ir, 16'h0000);
        chk("late ack reg_C1", reg_C1, 16'h0000);
        d_ack = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset sampled on rising clock.
REQ-003 SHALL have port state, input, 1, pipeline phase; logic advances only when state == `exec.
REQ-004 SHALL have port mem_ir, input, 16, instruction from execute stage; opcode is bits [15:11].
REQ-005 SHALL have port reg_C, input, 16, ALU result from execute stage, used as the data address for loads and stores.
REQ-006 SHALL have port dw, input, 1, store request from execute stage.
REQ-007 SHALL have port smdr1, input, 16, store data from execute stage.
REQ-008 SHALL have ports d_req (output, 1), d_we (output, 1), d_addr (output, 16) and d_wdata (output, 16), forming the data-memory request side; all are registered.
REQ-009 SHALL have ports d_ack (input, 1) and d_rdata (input, 16), forming the data-memory completion side.
REQ-010 SHALL have port wb_ir, output, 16, instruction to write-back; 16'h0000 is a bubble.
REQ-011 SHALL have port reg_C1, output, 16, write-back data: load data, or the pass-through reg_C value.
REQ-012 SHALL have port stall, output, 1, registered; high freezes upstream stages.
REQ-013 SHALL have port merr, output, 1, sticky flag set on memory timeout.

Function
REQ-014 SHALL implement FSM states IDLE and ACCESS, with a 4-bit wait counter.
REQ-015 IDLE, state == `exec, opcode == `LOAD or dw == 1: SHALL register the request on the next edge.
- d_req = 1, d_addr = reg_C, d_we = dw, d_wdata = smdr1.
- Latch mem_ir internally; wb_ir = 0; stall = 1; counter = 0; go to ACCESS.
REQ-016 IDLE, state == `exec, non-memory opcode: SHALL set wb_ir = mem_ir and reg_C1 = reg_C next edge (1-cycle latency), with stall = 0.
REQ-017 IDLE, state != `exec: SHALL hold all outputs.
REQ-018 ACCESS: SHALL keep d_req, d_we, d_addr and d_wdata stable until the edge where d_ack == 1 is sampled, regardless of state.
REQ-019 ACCESS, d_ack == 1: SHALL complete and return to IDLE.
- d_req = 0, d_we = 0, stall = 0, wb_ir = latched instruction.
- reg_C1 = d_rdata for LOAD; reg_C1 = d_addr for STORE.
REQ-020 ACCESS, no d_ack: SHALL increment the counter; if the counter reaches 15, SHALL abort.
- d_req = 0, merr = 1, wb_ir = 0, stall = 0; go to IDLE.
REQ-021 d_ack == 1 sampled in IDLE SHALL be ignored.
REQ-022 Minimum memory-op latency SHALL be 2 edges: request edge plus ack edge; ack is never sampled on the edge that raises d_req.
REQ-023 Upstream SHALL be assumed frozen while stall == 1; no new request is accepted until the FSM returns to IDLE.
REQ-024 A memory op directly following a completion SHALL be issued on the first `exec edge with stall == 0.

Reset
REQ-025 reset == 0 at a rising edge SHALL force IDLE, counter = 0, and all outputs to 0 (wb_ir = 16'h0000, reg_C1 = 0, d_* = 0, stall = 0, merr = 0), including mid-ACCESS; a late d_ack after reset is ignored.

Structure
REQ-026 Opcodes (`LOAD, `STORE), `exec and the timeout limit 15 SHALL come from the shared define.v.
REQ-027 FSM state encoding SHALL be local parameters.
REQ-028 No sub-module SHALL be used; the block is a single module.

Verification
REQ-029 ADD passes through: mem_ir = {`ADD, 11'h012}, reg_C = 16'h1234, state = `exec -> next edge wb_ir = mem_ir, reg_C1 = 16'h1234, stall = 0, d_req = 0.
REQ-030 LOAD with 3-cycle ack: reg_C = 16'h0040, d_rdata = 16'hBEEF, ack 3 edges after d_req -> stall high for 3 cycles, then reg_C1 = 16'hBEEF and wb_ir = LOAD.
REQ-031 STORE with immediate ack: dw = 1, smdr1 = 16'h5A5A, reg_C = 16'h0010 -> d_we = 1, d_wdata = 16'h5A5A, d_addr = 16'h0010; after ack, d_we = 0 and wb_ir = STORE.
REQ-032 Timeout: LOAD, d_ack held 0 -> after 15 wait edges merr = 1, wb_ir = 0, stall = 0, d_req = 0.
REQ-033 Reset mid-ACCESS: reset = 0 two cycles into a LOAD, then d_ack = 1 -> all outputs 0, no write-back occurs.
REQ-034 Back-to-back: STORE then LOAD, each acked after 1 cycle -> two distinct requests, d_req low for at least one cycle between them, both complete in order.
